// File: rtl/iommu_reg_arbiter_if.sv
// Register-bus bundle between the requester-side converters, the arbiter and the register map.
// The slave modport is the arbiter's view; master is the view of the surrounding requesters/register map.
interface iommu_reg_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [NUM_REQ-1:0]                 req_valid_i;
  logic [NUM_REQ-1:0]                 req_write_i;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata_i;
  logic [NUM_REQ-1:0][STRB_WIDTH-1:0] req_wstrb_i;

  logic [NUM_REQ-1:0]                 rsp_ready_o;
  logic [DATA_WIDTH-1:0]              rsp_rdata_o;
  logic                               rsp_error_o;

  logic                               reg_valid_o;
  logic                               reg_write_o;
  logic [ADDR_WIDTH-1:0]              reg_addr_o;
  logic [DATA_WIDTH-1:0]              reg_wdata_o;
  logic [STRB_WIDTH-1:0]              reg_wstrb_o;
  logic                               reg_ready_i;
  logic [DATA_WIDTH-1:0]              reg_rdata_i;
  logic                               reg_error_i;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i,
    input  reg_ready_i, reg_rdata_i, reg_error_i,
    output rsp_ready_o, rsp_rdata_o, rsp_error_o,
    output reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i,
    output reg_ready_i, reg_rdata_i, reg_error_i,
    input  rsp_ready_o, rsp_rdata_o, rsp_error_o,
    input  reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o
  );
endinterface

// File: rtl/iommu_reg_arbiter.sv
// Round-robin arbiter sharing the IOMMU register-map port among NUM_REQ requesters,
// holding each grant until completion, with a per-access watchdog.
module iommu_reg_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  iommu_reg_arbiter_if.slave   bus,
  output logic                 busy_o,
  output logic                 timeout_o
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] g, g_nxt;
  logic [GW-1:0] ptr, ptr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [GW-1:0] sel;
  logic          sel_any;
  logic [GW-1:0] g_inc;
  logic          active;
  logic          owner_vld;
  logic          done_ok;
  logic          done_to;

  // Outputs are forced quiet while reset is asserted, even if an access was in flight.
  assign active    = (state == BUSY) && !rst_i;
  assign owner_vld = bus.req_valid_i[g];
  assign done_ok   = active && owner_vld && bus.reg_ready_i;
  assign done_to   = active && owner_vld && !bus.reg_ready_i &&
                     (TIMEOUT != 0) && (cnt == CNT_LAST);
  assign g_inc     = (g == GW'(NUM_REQ - 1)) ? '0 : g + GW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      g     <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    // Scan downward so the last hit is the first set bit at or above ptr (wrapping).
    sel     = ptr;
    sel_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(ptr) + i) % NUM_REQ;
      if (bus.req_valid_i[idx]) begin
        sel     = GW'(idx);
        sel_any = 1'b1;
      end
    end

    state_nxt = state;
    g_nxt     = g;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (sel_any) begin
          state_nxt = BUSY;
          g_nxt     = sel;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (!owner_vld) begin
          state_nxt = IDLE;
        end else if (done_ok || done_to) begin
          state_nxt = IDLE;
          ptr_nxt   = g_inc;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.reg_valid_o = 1'b0;
    bus.reg_write_o = 1'b0;
    bus.reg_addr_o  = '0;
    bus.reg_wdata_o = '0;
    bus.reg_wstrb_o = '0;
    bus.rsp_ready_o = '0;
    bus.rsp_rdata_o = '0;
    bus.rsp_error_o = 1'b0;
    busy_o          = active;
    timeout_o       = 1'b0;
    if (active) begin
      bus.reg_valid_o = owner_vld;
      bus.reg_write_o = bus.req_write_i[g];
      bus.reg_addr_o  = bus.req_addr_i[g];
      bus.reg_wdata_o = bus.req_wdata_i[g];
      bus.reg_wstrb_o = bus.req_wstrb_i[g];
    end
    if (done_ok) begin
      bus.rsp_ready_o = NUM_REQ'(1) << g;
      bus.rsp_rdata_o = bus.reg_rdata_i;
      bus.rsp_error_o = bus.reg_error_i;
    end else if (done_to) begin
      bus.rsp_ready_o = NUM_REQ'(1) << g;
      bus.rsp_error_o = 1'b1;
      timeout_o       = 1'b1;
    end
  end
endmodule

// File: tb/tb_iommu_reg_arbiter.sv
// Bench for iommu_reg_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic compared against a cycle-counting reference model.
module tb_iommu_reg_arbiter;
  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic tmo;

  iommu_reg_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  iommu_reg_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus      (bus),
    .busy_o   (busy),
    .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] fa [NR] = '{32'h0000_0018, 32'h0000_0024};
  logic [DW-1:0] fw [NR] = '{32'h1111_1111, 32'h2222_2222};
  logic [SW-1:0] fs [NR] = '{4'hF, 4'h3};

  typedef struct {
    logic          rst;
    logic [NR-1:0] v;
    logic [NR-1:0] w;
    logic          rdy;
    logic [DW-1:0] rd;
    logic          er;
    logic          e_rv;
    logic          e_rw;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [SW-1:0] e_ws;
    logic [NR-1:0] e_rr;
    logic [DW-1:0] e_rd;
    logic          e_er;
    logic          e_busy;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t row(logic r, logic [NR-1:0] v, logic [NR-1:0] w, logic rdy,
                               logic [DW-1:0] rd, logic er, int eg, logic [NR-1:0] e_rr,
                               logic [DW-1:0] e_rd, logic e_er);
    vec_t t;
    t.rst = r; t.v = v; t.w = w; t.rdy = rdy; t.rd = rd; t.er = er;
    t.e_rv   = (eg >= 0);
    t.e_busy = (eg >= 0);
    t.e_rw   = (eg >= 0) ? w[eg]  : 1'b0;
    t.e_addr = (eg >= 0) ? fa[eg] : '0;
    t.e_wd   = (eg >= 0) ? fw[eg] : '0;
    t.e_ws   = (eg >= 0) ? fs[eg] : '0;
    t.e_rr = e_rr; t.e_rd = e_rd; t.e_er = e_er;
    return t;
  endfunction

  task automatic drive(input logic r, input logic [NR-1:0] v, input logic [NR-1:0] w,
                       input logic rdy, input logic [DW-1:0] rd, input logic er);
    rst = r;
    bus.req_valid_i = v;
    bus.req_write_i = w;
    for (int i = 0; i < NR; i++) begin
      bus.req_addr_i[i]  = fa[i];
      bus.req_wdata_i[i] = fw[i];
      bus.req_wstrb_i[i] = fs[i];
    end
    bus.reg_ready_i = rdy;
    bus.reg_rdata_i = rd;
    bus.reg_error_i = er;
  endtask

  task automatic cyc(input logic r, input logic [NR-1:0] v, input logic [NR-1:0] w,
                     input logic rdy, input logic [DW-1:0] rd, input logic er);
    @(negedge clk);
    drive(r, v, w, rdy, rd, er);
    #1;
  endtask

  // Reference model state: busy flag, granted index, round-robin pointer, BUSY cycle number (1-based).
  bit m_busy;
  int m_g;
  int m_ptr;
  int m_n;
  logic [NR-1:0] pend;
  logic [AW-1:0] ra [NR];
  logic [DW-1:0] rwd [NR];
  logic [SW-1:0] rws [NR];
  logic [NR-1:0] rwr;

  initial begin
    vec_t t;
    logic          e_rv, e_rw, e_er, e_busy, e_to, skip_req;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_rd;
    logic [SW-1:0] e_ws;
    logic [NR-1:0] e_rr;

    drive(1'b1, '0, '0, 1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);

    // Single read, contention writes, wait states with error.
    tbl[0]  = row(1, 2'b00, 2'b00, 0, 32'h0,        0, -1, 2'b00, 32'h0,        0);
    tbl[1]  = row(0, 2'b01, 2'b00, 0, 32'h0,        0, -1, 2'b00, 32'h0,        0);
    tbl[2]  = row(0, 2'b01, 2'b00, 1, 32'hDEADBEEF, 0,  0, 2'b01, 32'hDEADBEEF, 0);
    tbl[3]  = row(0, 2'b00, 2'b00, 0, 32'h0,        0, -1, 2'b00, 32'h0,        0);
    tbl[4]  = row(0, 2'b11, 2'b11, 0, 32'h0,        0, -1, 2'b00, 32'h0,        0);
    tbl[5]  = row(0, 2'b11, 2'b11, 1, 32'h0,        0,  1, 2'b10, 32'h0,        0);
    tbl[6]  = row(0, 2'b11, 2'b11, 0, 32'h0,        0, -1, 2'b00, 32'h0,        0);
    tbl[7]  = row(0, 2'b11, 2'b11, 1, 32'h0,        0,  0, 2'b01, 32'h0,        0);
    tbl[8]  = row(0, 2'b11, 2'b11, 0, 32'h0,        0, -1, 2'b00, 32'h0,        0);
    tbl[9]  = row(0, 2'b11, 2'b11, 1, 32'h0,        0,  1, 2'b10, 32'h0,        0);
    tbl[10] = row(0, 2'b01, 2'b00, 0, 32'h0,        0, -1, 2'b00, 32'h0,        0);
    for (int i = 11; i <= 15; i++)
      tbl[i] = row(0, 2'b01, 2'b00, 0, 32'h77, 1, 0, 2'b00, 32'h0, 0);
    tbl[16] = row(0, 2'b01, 2'b00, 1, 32'h5A,       1,  0, 2'b01, 32'h5A,       1);
    tbl[17] = row(0, 2'b00, 2'b00, 0, 32'h0,        0, -1, 2'b00, 32'h0,        0);

    for (int i = 0; i < 18; i++) begin
      t = tbl[i];
      cyc(t.rst, t.v, t.w, t.rdy, t.rd, t.er);
      chk($sformatf("t%0d_reg_valid", i), 64'(bus.reg_valid_o), 64'(t.e_rv));
      chk($sformatf("t%0d_reg_write", i), 64'(bus.reg_write_o), 64'(t.e_rw));
      chk($sformatf("t%0d_reg_addr", i),  64'(bus.reg_addr_o),  64'(t.e_addr));
      chk($sformatf("t%0d_reg_wdata", i), 64'(bus.reg_wdata_o), 64'(t.e_wd));
      chk($sformatf("t%0d_reg_wstrb", i), 64'(bus.reg_wstrb_o), 64'(t.e_ws));
      chk($sformatf("t%0d_rsp_ready", i), 64'(bus.rsp_ready_o), 64'(t.e_rr));
      chk($sformatf("t%0d_rsp_rdata", i), 64'(bus.rsp_rdata_o), 64'(t.e_rd));
      chk($sformatf("t%0d_rsp_error", i), 64'(bus.rsp_error_o), 64'(t.e_er));
      chk($sformatf("t%0d_busy", i),      64'(busy),            64'(t.e_busy));
      chk($sformatf("t%0d_timeout", i),   64'(tmo),             64'(1'b0));
    end

    // Timeout: requester 0 granted, register map never ready.
    cyc(1, 2'b00, 2'b00, 0, 32'h0, 0);
    cyc(0, 2'b01, 2'b00, 0, 32'h0, 0);
    for (int k = 1; k <= 7; k++) begin
      cyc(0, 2'b01, 2'b00, 0, 32'hFFFF_FFFF, 0);
      chk($sformatf("to_wait%0d_rsp_ready", k), 64'(bus.rsp_ready_o), 64'(2'b00));
      chk($sformatf("to_wait%0d_timeout", k),   64'(tmo),             64'(1'b0));
      chk($sformatf("to_wait%0d_reg_valid", k), 64'(bus.reg_valid_o), 64'(1'b1));
    end
    cyc(0, 2'b01, 2'b00, 0, 32'hFFFF_FFFF, 0);
    chk("to_fire_rsp_ready", 64'(bus.rsp_ready_o), 64'(2'b01));
    chk("to_fire_rsp_error", 64'(bus.rsp_error_o), 64'(1'b1));
    chk("to_fire_rsp_rdata", 64'(bus.rsp_rdata_o), 64'(32'h0));
    chk("to_fire_timeout",   64'(tmo),             64'(1'b1));
    cyc(0, 2'b11, 2'b00, 0, 32'h0, 0);
    chk("to_after_busy",    64'(busy), 64'(1'b0));
    chk("to_after_timeout", 64'(tmo),  64'(1'b0));
    cyc(0, 2'b11, 2'b00, 1, 32'h33, 0);
    chk("to_ptr_adv_addr",  64'(bus.reg_addr_o),  64'(fa[1]));
    chk("to_ptr_adv_ready", 64'(bus.rsp_ready_o), 64'(2'b10));

    // Reset in the third BUSY cycle of a requester-1 access with the pointer at 1.
    cyc(0, 2'b01, 2'b00, 0, 32'h0, 0);
    cyc(0, 2'b01, 2'b00, 1, 32'h0, 0);
    cyc(0, 2'b10, 2'b00, 0, 32'h0, 0);
    cyc(0, 2'b10, 2'b00, 0, 32'h0, 0);
    chk("rst_busy1_reg_valid", 64'(bus.reg_valid_o), 64'(1'b1));
    cyc(0, 2'b10, 2'b00, 0, 32'h0, 0);
    cyc(1, 2'b10, 2'b00, 1, 32'h44, 1);
    chk("rst_during_rsp_ready", 64'(bus.rsp_ready_o), 64'(2'b00));
    chk("rst_during_reg_valid", 64'(bus.reg_valid_o), 64'(1'b0));
    chk("rst_during_busy",      64'(busy),            64'(1'b0));
    cyc(0, 2'b11, 2'b00, 0, 32'h0, 0);
    chk("rst_after_rsp_ready", 64'(bus.rsp_ready_o), 64'(2'b00));
    chk("rst_after_reg_valid", 64'(bus.reg_valid_o), 64'(1'b0));
    chk("rst_after_reg_addr",  64'(bus.reg_addr_o),  64'(32'h0));
    chk("rst_after_busy",      64'(busy),            64'(1'b0));
    cyc(0, 2'b11, 2'b00, 1, 32'h55, 0);
    chk("rst_regrant_addr",  64'(bus.reg_addr_o),  64'(fa[0]));
    chk("rst_regrant_ready", 64'(bus.rsp_ready_o), 64'(2'b01));

    // Withdrawal with reg_ready in the same cycle; pointer stays at 1.
    cyc(0, 2'b10, 2'b00, 0, 32'h0, 0);
    cyc(0, 2'b00, 2'b00, 1, 32'h99, 0);
    chk("wd_reg_valid", 64'(bus.reg_valid_o), 64'(1'b0));
    chk("wd_rsp_ready", 64'(bus.rsp_ready_o), 64'(2'b00));
    chk("wd_rsp_rdata", 64'(bus.rsp_rdata_o), 64'(32'h0));
    cyc(0, 2'b11, 2'b00, 0, 32'h0, 0);
    chk("wd_after_busy", 64'(busy), 64'(1'b0));
    cyc(0, 2'b11, 2'b00, 1, 32'h0, 0);
    chk("wd_ptr_kept_addr",  64'(bus.reg_addr_o),  64'(fa[1]));
    chk("wd_ptr_kept_ready", 64'(bus.rsp_ready_o), 64'(2'b10));

    // Randomized traffic against the reference model, starting from a reset.
    pend = '0;
    m_busy = 0; m_g = 0; m_ptr = 0; m_n = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst = (c == 0) || ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          ra[i]   = $urandom;
          rwd[i]  = $urandom;
          rws[i]  = SW'($urandom);
          rwr[i]  = 1'($urandom);
        end else if (pend[i] && $urandom_range(0, 39) == 0) begin
          pend[i] = 1'b0;
        end
        bus.req_addr_i[i]  = ra[i];
        bus.req_wdata_i[i] = rwd[i];
        bus.req_wstrb_i[i] = rws[i];
      end
      bus.req_valid_i = pend;
      bus.req_write_i = rwr;
      bus.reg_ready_i = ($urandom_range(0, 9) < 3);
      bus.reg_rdata_i = $urandom;
      bus.reg_error_i = 1'($urandom);
      #1;

      e_rv = 0; e_rw = 0; e_addr = '0; e_wd = '0; e_ws = '0;
      e_rr = '0; e_rd = '0; e_er = 0; e_busy = 0; e_to = 0; skip_req = 0;
      if (rst) begin
        m_busy = 0;
        m_ptr  = 0;
      end else if (!m_busy) begin
        for (int k = NR - 1; k >= 0; k--) begin
          int cand;
          cand = (m_ptr + k) % NR;
          if (pend[cand]) begin
            m_g = cand;
            m_busy = 1;
          end
        end
        m_n = 1;
      end else if (!pend[m_g]) begin
        e_busy = 1;
        skip_req = 1;
        m_busy = 0;
      end else begin
        e_busy = 1;
        e_rv   = 1;
        e_rw   = rwr[m_g];
        e_addr = ra[m_g];
        e_wd   = rwd[m_g];
        e_ws   = rws[m_g];
        if (bus.reg_ready_i) begin
          e_rr = NR'(1) << m_g;
          e_rd = bus.reg_rdata_i;
          e_er = bus.reg_error_i;
        end else if (m_n == TO) begin
          e_rr = NR'(1) << m_g;
          e_er = 1;
          e_to = 1;
        end else begin
          m_n++;
        end
        if (e_rr != '0) begin
          m_busy = 0;
          m_ptr  = (m_g + 1) % NR;
        end
      end

      chk($sformatf("r%0d_reg_valid", c), 64'(bus.reg_valid_o), 64'(e_rv));
      chk($sformatf("r%0d_rsp_ready", c), 64'(bus.rsp_ready_o), 64'(e_rr));
      chk($sformatf("r%0d_rsp_rdata", c), 64'(bus.rsp_rdata_o), 64'(e_rd));
      chk($sformatf("r%0d_rsp_error", c), 64'(bus.rsp_error_o), 64'(e_er));
      chk($sformatf("r%0d_busy", c),      64'(busy),            64'(e_busy));
      chk($sformatf("r%0d_timeout", c),   64'(tmo),             64'(e_to));
      if (!skip_req) begin
        chk($sformatf("r%0d_reg_write", c), 64'(bus.reg_write_o), 64'(e_rw));
        chk($sformatf("r%0d_reg_addr", c),  64'(bus.reg_addr_o),  64'(e_addr));
        chk($sformatf("r%0d_reg_wdata", c), 64'(bus.reg_wdata_o), 64'(e_wd));
        chk($sformatf("r%0d_reg_wstrb", c), 64'(bus.reg_wstrb_o), 64'(e_ws));
      end
      for (int i = 0; i < NR; i++)
        if (e_rr[i]) pend[i] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
